// File: rtl/palu_pkg.sv
// Shared definitions for the poor-man's ALU arbiter slice.
//   state_t    : sequencer states (IDLE -> WAIT -> RESP -> IDLE)
//   SEL_*      : ALU selector encodings; bit 1 picks the logic unit
//   CNT_W      : width of the ALU latency wait counter
//   mask_carry : carry reported to a requester (the logic unit has no carry)
package palu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SEL_ADD   = 2'b00;
  localparam logic [1:0] SEL_SUB   = 2'b01;
  localparam logic [1:0] SEL_LOGIC = 2'b10;

  localparam int CNT_W = 3;

  // The boolean unit's carry_out is meaningless, so it is reported as 0.
  function automatic logic mask_carry(input logic [1:0] sel, input logic carry);
    return ((sel & SEL_LOGIC) != 2'b00) ? 1'b0 : carry;
  endfunction

endpackage

// File: rtl/palu_rr_arbiter2.sv
// Two-way round-robin arbiter with its own last-grant history.
// Ports:
//   clk, rst_n  : clock / asynchronous active-low reset
//   req_valid   : [0] requester 0 valid, [1] requester 1 valid
//   grant_take  : the granted request is being accepted this cycle
//   grant_valid : at least one requester is asking
//   grant_id    : requester that wins if accepted this cycle
module palu_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       grant_take,
  output logic       grant_valid,
  output logic       grant_id
);

  // Reset value 1 makes requester 0 the winner of the first contested grant.
  logic last_grant_reg;

  always_comb begin
    grant_valid = |req_valid;
    grant_id    = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_reg;
      default: grant_id = 1'b0;
    endcase
  end

  // History only moves on an actual acceptance, never on a bare valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
    end else if (grant_take && grant_valid) begin
      last_grant_reg <= grant_id;
    end
  end

endmodule

// File: rtl/palu_arbiter.sv
// Shares one 4-bit ALU between two requesters. A round-robin winner's
// operands/selector are registered onto the ALU, the result is sampled
// ALU_LATENCY cycles later and returned on a valid/ready response channel
// tagged with the requester id.
// Ports:
//   clk, rst_n                    : clock / asynchronous active-low reset
//   reqN_valid/ready              : request handshake for requester N (0,1)
//   reqN_operand_one/two/selector : request payload for requester N
//   alu_operand_one/two, alu_selector : registered drive to the ALU
//   alu_result, alu_carry         : ALU outputs
//   rsp_valid/ready               : response handshake
//   rsp_result, rsp_carry, rsp_id : captured response and originating requester
module palu_arbiter
  import palu_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_operand_one,
  input  logic [3:0] req0_operand_two,
  input  logic [1:0] req0_selector,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_operand_one,
  input  logic [3:0] req1_operand_two,
  input  logic [1:0] req1_selector,
  output logic [3:0] alu_operand_one,
  output logic [3:0] alu_operand_two,
  output logic [1:0] alu_selector,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_id
);

  generate
    if (ALU_LATENCY < 1 || ALU_LATENCY > 7) begin : g_bad_latency
      $error("palu_arbiter: ALU_LATENCY must be in 1..7");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LATENCY - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       alu_a_reg, alu_a_next;
  logic [3:0]       alu_b_reg, alu_b_next;
  logic [1:0]       alu_sel_reg, alu_sel_next;
  logic [3:0]       rsp_result_reg, rsp_result_next;
  logic             rsp_carry_reg, rsp_carry_next;
  logic             rsp_id_reg, rsp_id_next;

  logic grant_valid;
  logic grant_id;
  logic accept;

  palu_rr_arbiter2 u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   ({req1_valid, req0_valid}),
    .grant_take  (accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Readies are only ever offered in IDLE, so one bubble cycle separates
  // each response handshake from the next acceptance.
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    alu_a_next      = alu_a_reg;
    alu_b_next      = alu_b_reg;
    alu_sel_next    = alu_sel_reg;
    rsp_result_next = rsp_result_reg;
    rsp_carry_next  = rsp_carry_reg;
    rsp_id_next     = rsp_id_reg;
    accept          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          accept       = 1'b1;
          alu_a_next   = grant_id ? req1_operand_one : req0_operand_one;
          alu_b_next   = grant_id ? req1_operand_two : req0_operand_two;
          alu_sel_next = grant_id ? req1_selector    : req0_selector;
          rsp_id_next  = grant_id;
          cnt_next     = LAT_M1;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        // alu_* stay stable here; the selector used for masking is the one
        // actually presented to the ALU.
        if (cnt_reg == '0) begin
          rsp_result_next = alu_result;
          rsp_carry_next  = mask_carry(alu_sel_reg, alu_carry);
          state_next      = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_sel_reg    <= '0;
      rsp_result_reg <= '0;
      rsp_carry_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      alu_a_reg      <= alu_a_next;
      alu_b_reg      <= alu_b_next;
      alu_sel_reg    <= alu_sel_next;
      rsp_result_reg <= rsp_result_next;
      rsp_carry_reg  <= rsp_carry_next;
      rsp_id_reg     <= rsp_id_next;
    end
  end

  assign alu_operand_one = alu_a_reg;
  assign alu_operand_two = alu_b_reg;
  assign alu_selector    = alu_sel_reg;
  assign rsp_valid       = (state_reg == RESP);
  assign rsp_result      = rsp_result_reg;
  assign rsp_carry       = rsp_carry_reg;
  assign rsp_id          = rsp_id_reg;

endmodule

// File: tb/tb_palu_arbiter.sv
// Scoreboard bench for palu_arbiter with a behavioural 4-bit ALU attached.
// Stimulus pushes hand-computed expected responses; a negedge monitor pops
// and compares on every response handshake.
module tb_palu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_operand_one, req0_operand_two;
  logic [1:0] req0_selector;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_operand_one, req1_operand_two;
  logic [1:0] req1_selector;
  logic [3:0] alu_operand_one, alu_operand_two;
  logic [1:0] alu_selector;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry, rsp_id;

  always #5 clk = ~clk;

  palu_arbiter #(.ALU_LATENCY(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req0_valid       (req0_valid),
    .req0_ready       (req0_ready),
    .req0_operand_one (req0_operand_one),
    .req0_operand_two (req0_operand_two),
    .req0_selector    (req0_selector),
    .req1_valid       (req1_valid),
    .req1_ready       (req1_ready),
    .req1_operand_one (req1_operand_one),
    .req1_operand_two (req1_operand_two),
    .req1_selector    (req1_selector),
    .alu_operand_one  (alu_operand_one),
    .alu_operand_two  (alu_operand_two),
    .alu_selector     (alu_selector),
    .alu_result       (alu_result),
    .alu_carry        (alu_carry),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_carry        (rsp_carry),
    .rsp_id           (rsp_id)
  );

  // Combinational ALU: add/sub with carry (sub carry = no borrow);
  // logic unit AND (sel=10) / OR (sel=11) and always drives carry=1.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum    = {1'b0, alu_operand_one}
               + {1'b0, (alu_selector[0] ? ~alu_operand_two : alu_operand_two)}
               + {4'b0, alu_selector[0]};
    alu_result = alu_sum[3:0];
    alu_carry  = alu_sum[4];
    if (alu_selector[1]) begin
      alu_result = alu_selector[0] ? (alu_operand_one | alu_operand_two)
                                   : (alu_operand_one & alu_operand_two);
      alu_carry  = 1'b1;
    end
  end

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic [3:0] r;
    logic       c;
  } vec_t;

  typedef struct packed {
    logic       id;
    logic [3:0] r;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  vec_t v0[$];
  vec_t v1[$];
  int   grant_log[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic last_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one line per completed response transaction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL spurious_rsp: got id=%0d result=%0h carry=%0d, expected no response",
                 rsp_id, rsp_result, rsp_carry);
      end else begin
        e = exp_q.pop_front();
        $display("rsp: id=%0d result=%0h carry=%0d (exp id=%0d result=%0h carry=%0d)",
                 rsp_id, rsp_result, rsp_carry, e.id, e.r, e.c);
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_result", 32'(rsp_result), 32'(e.r));
        chk("rsp_carry", 32'(rsp_carry), 32'(e.c));
      end
    end
  end

  task automatic drive_reqs();
    req0_valid = (v0.size() > 0);
    req1_valid = (v1.size() > 0);
    if (v0.size() > 0) begin
      req0_operand_one = v0[0].a;
      req0_operand_two = v0[0].b;
      req0_selector    = v0[0].sel;
    end
    if (v1.size() > 0) begin
      req1_operand_one = v1[0].a;
      req1_operand_two = v1[0].b;
      req1_selector    = v1[0].sel;
    end
  endtask

  // Offers the pending requests, checks each grant and queues its response.
  // Returns 1ns after the edge that accepted the last of nops operations.
  task automatic contend(input int nops);
    int   done = 0;
    int   cyc = 0;
    logic exp_id;
    drive_reqs();
    while (done < nops && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (req0_ready || req1_ready) begin
        exp_id = (v0.size() > 0 && v1.size() > 0) ? ~last_model : (v1.size() > 0);
        chk("grant_one_hot", 32'(req0_ready & req1_ready), 32'd0);
        chk("grant_id", 32'(req1_ready), 32'(exp_id));
        grant_log.push_back(int'(req1_ready));
        if (req1_ready && v1.size() > 0) begin
          exp_q.push_back('{1'b1, v1[0].r, v1[0].c});
          void'(v1.pop_front());
          last_model = 1'b1;
        end else if (!req1_ready && v0.size() > 0) begin
          exp_q.push_back('{1'b0, v0[0].r, v0[0].c});
          void'(v0.pop_front());
          last_model = 1'b0;
        end
        done++;
      end
      @(posedge clk);
      #1;
      drive_reqs();
    end
    if (done < nops) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL contend_timeout: got %0d acceptances, expected %0d", done, nops);
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() > 0 && c < 30) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() > 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[4];
    int n;
    exp_order = '{0, 1, 0, 1};

    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_operand_one = '0; req0_operand_two = '0; req0_selector = '0;
    req1_valid = 1'b0; req1_operand_one = '0; req1_operand_two = '0; req1_selector = '0;
    last_model = 1'b1;

    // Reset state
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_alu_a", 32'(alu_operand_one), 32'd0);
    chk("rst_alu_b", 32'(alu_operand_two), 32'd0);
    chk("rst_alu_sel", 32'(alu_selector), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add 7+5, cycle-exact timing
    req0_valid = 1'b1; req0_operand_one = 4'h7; req0_operand_two = 4'h5; req0_selector = 2'b00;
    @(negedge clk);
    chk("add_req0_ready", 32'(req0_ready), 32'd1);
    chk("add_req1_ready", 32'(req1_ready), 32'd0);
    exp_q.push_back('{1'b0, 4'hC, 1'b0});
    last_model = 1'b0;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    chk("add_alu_a", 32'(alu_operand_one), 32'h7);
    chk("add_alu_b", 32'(alu_operand_two), 32'h5);
    chk("add_alu_sel", 32'(alu_selector), 32'h0);
    @(negedge clk);
    chk("add_rsp_valid_wait", 32'(rsp_valid), 32'd0);
    chk("add_ready_in_wait", 32'(req0_ready), 32'd0);
    @(negedge clk);
    chk("add_rsp_valid_cap", 32'(rsp_valid), 32'd1);
    wait_drain();
    chk("idle_alu_hold", 32'(alu_operand_one), 32'h7);

    // Add overflow 9+8 from requester 1
    v1.push_back('{4'h9, 4'h8, 2'b00, 4'h1, 1'b1});
    contend(1);
    wait_drain();

    // Contention: four ops, grants must alternate 0,1,0,1
    grant_log.delete();
    v0.push_back('{4'h3, 4'h4, 2'b00, 4'h7, 1'b0});
    v1.push_back('{4'hA, 4'h3, 2'b01, 4'h7, 1'b1});
    v0.push_back('{4'hF, 4'h1, 2'b01, 4'hE, 1'b1});
    v1.push_back('{4'h6, 4'h3, 2'b10, 4'h2, 1'b0});
    contend(4);
    wait_drain();
    n = grant_log.size();
    chk("contend_grants", 32'(n), 32'd4);
    for (int i = 0; i < 4 && i < n; i++) begin
      chk("contend_order", 32'(grant_log[i]), 32'(exp_order[i]));
    end

    // Backpressure: 5-2 held for 5 cycles while requester 1 waits
    rsp_ready = 1'b0;
    v0.push_back('{4'h5, 4'h2, 2'b01, 4'h3, 1'b1});
    contend(1);
    req1_valid = 1'b1; req1_operand_one = 4'h8; req1_operand_two = 4'h1; req1_selector = 2'b11;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", 32'(rsp_result), 32'h3);
      chk("bp_rsp_carry", 32'(rsp_carry), 32'd1);
      chk("bp_rsp_id", 32'(rsp_id), 32'd0);
      chk("bp_req0_ready", 32'(req0_ready), 32'd0);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_at_handshake", 32'(req1_ready), 32'd0);
    @(negedge clk);
    chk("bp_resume_ready", 32'(req1_ready), 32'd1);
    exp_q.push_back('{1'b1, 4'h9, 1'b0});
    last_model = 1'b1;
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_drain();

    // Logic op: ALU drives carry=1, response carry must be 0
    v0.push_back('{4'hA, 4'h6, 2'b11, 4'hE, 1'b0});
    contend(1);
    wait_drain();

    // Reset during WAIT discards the op; requester 0 wins first afterwards
    v1.push_back('{4'h2, 4'h2, 2'b00, 4'h4, 1'b0});
    contend(1);
    chk("wait_alu_a", 32'(alu_operand_one), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_operand_one), 32'd0);
    chk("mid_rst_alu_b", 32'(alu_operand_two), 32'd0);
    chk("mid_rst_alu_sel", 32'(alu_selector), 32'd0);
    exp_q.delete();
    last_model = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    grant_log.delete();
    v0.push_back('{4'h1, 4'h1, 2'b00, 4'h2, 1'b0});
    v1.push_back('{4'hC, 4'h4, 2'b10, 4'h4, 1'b0});
    contend(2);
    wait_drain();
    n = grant_log.size();
    chk("post_rst_grants", 32'(n), 32'd2);
    if (n > 0) chk("post_rst_first", 32'(grant_log[0]), 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
